// File: rtl/multdiv_engine.sv
// Iterative signed multiply/divide unit: radix-2 Booth multiply and restoring divide,
// one bit per clock, with a fixed latency of WIDTH+1 edges from the start edge.
module multdiv_engine #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [2*WIDTH:0] acc_q;
  logic [WIDTH-1:0] opnd_q;
  logic             neg_q;
  logic             div0_q;
  logic             dovf_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy_q;
  logic             busy_q;

  logic [WIDTH:0]     upper_ext_s;
  logic [WIDTH:0]     addend_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH:0]   acc_mul_d;
  logic [WIDTH:0]     rem_shift_s;
  logic [WIDTH+1:0]   diff_s;
  logic [2*WIDTH:0]   acc_div_d;
  logic [2*WIDTH-1:0] prod_s;
  logic               mul_exc_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   div_res_s;
  logic               div_exc_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;

  // Datapath: one Booth step, one restoring-divide step, and result finalisation.
  always_comb begin
    // acc_q holds {accumulator, multiplier, booth bit}; the accumulator is widened by
    // one bit so the arithmetic shift always brings in the true sign of the sum.
    upper_ext_s = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
    case (acc_q[1:0])
      2'b01:   addend_s = {opnd_q[WIDTH-1], opnd_q};
      2'b10:   addend_s = -{opnd_q[WIDTH-1], opnd_q};
      default: addend_s = {(WIDTH+1){1'b0}};
    endcase
    sum_s     = upper_ext_s + addend_s;
    acc_mul_d = {sum_s, acc_q[WIDTH:1]};

    // For divide acc_q holds {remainder (WIDTH+1 bits), dividend/quotient}.
    rem_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff_s      = {1'b0, rem_shift_s} - {2'b00, opnd_q};
    if (diff_s[WIDTH+1]) begin
      acc_div_d = {rem_shift_s, acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_div_d = {diff_s[WIDTH:0], acc_q[WIDTH-2:0], 1'b1};
    end

    prod_s    = acc_q[2*WIDTH:1];
    mul_exc_s = (|prod_s[2*WIDTH-1:WIDTH-1]) && !(&prod_s[2*WIDTH-1:WIDTH-1]);

    quot_s = acc_q[WIDTH-1:0];
    if (div0_q) begin
      div_res_s = {WIDTH{1'b0}};
      div_exc_s = 1'b1;
    end else if (dovf_q) begin
      div_res_s = MIN_VAL;
      div_exc_s = 1'b1;
    end else begin
      div_res_s = neg_q ? -quot_s : quot_s;
      div_exc_s = 1'b0;
    end

    abs_a_s = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    abs_b_s = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  end

  // Control FSM; a start in any state restarts, MUL taking priority over DIV.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      acc_q    <= {(2*WIDTH+1){1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      dovf_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (ctrl_MULT) begin
      state_q <= MUL;
      cnt_q   <= {CW{1'b0}};
      acc_q   <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
      opnd_q  <= data_operandA;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
      dovf_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else if (ctrl_DIV) begin
      state_q <= DIV;
      cnt_q   <= {CW{1'b0}};
      acc_q   <= {{(WIDTH+1){1'b0}}, abs_a_s};
      opnd_q  <= abs_b_s;
      neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div0_q  <= (data_operandB == {WIDTH{1'b0}});
      dovf_q  <= (data_operandA == MIN_VAL) && (data_operandB == {WIDTH{1'b1}});
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        MUL: begin
          if (cnt_q == CW'(WIDTH)) begin
            result_q <= prod_s[WIDTH-1:0];
            exc_q    <= mul_exc_s;
            rdy_q    <= 1'b1;
            state_q  <= DONE;
          end else begin
            acc_q <= acc_mul_d;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DIV: begin
          if (cnt_q == CW'(WIDTH)) begin
            result_q <= div_res_s;
            exc_q    <= div_exc_s;
            rdy_q    <= 1'b1;
            state_q  <= DONE;
          end else begin
            acc_q <= acc_div_d;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_engine.sv
// Self-checking bench for multdiv_engine: an arithmetic reference model checked every
// cycle, plus literal expectations for the directed vectors.
module tb_multdiv_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  multdiv_engine #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;

  // literal expectations set by the stimulus
  int          lit_edge = -100;
  logic        lit_valid = 1'b0;
  logic [31:0] lit_res = 32'd0;
  logic        lit_exc = 1'b0;
  int          lit_rst_edge = -100;

  // reference model state
  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  logic [32:0] m_next = 33'd0;
  logic        m_rdy = 1'b0;
  logic        m_busy = 1'b0;
  logic [31:0] m_res = 32'd0;
  logic        m_exc = 1'b0;
  wire         m_fin = m_pend && (m_cnt == 1);
  wire         start = ctrl_MULT || ctrl_DIV;

  function automatic logic [32:0] calc(input logic is_mul, input logic [31:0] a,
                                       input logic [31:0] b);
    longint p;
    int     q;
    logic [31:0] lo;
    if (is_mul) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      lo = p[31:0];
      return {(p != longint'($signed(lo))), lo};
    end else if (b == 32'd0) begin
      return {1'b1, 32'd0};
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      return {1'b1, 32'h8000_0000};
    end else begin
      q = $signed(a) / $signed(b);
      return {1'b0, q};
    end
  endfunction

  always @(posedge clock) begin
    edge_cnt <= edge_cnt + 1;
    if (reset) begin
      m_pend <= 1'b0;
      m_cnt  <= 0;
      m_rdy  <= 1'b0;
      m_busy <= 1'b0;
      m_res  <= 32'd0;
      m_exc  <= 1'b0;
    end else begin
      m_rdy  <= m_fin;
      m_busy <= start || m_pend;
      if (m_fin) begin
        m_res <= m_next[31:0];
        m_exc <= m_next[32];
      end
      if (start) begin
        m_pend <= 1'b1;
        m_cnt  <= 33;
        m_next <= calc(ctrl_MULT, data_operandA, data_operandB);
      end else if (m_fin) begin
        m_pend <= 1'b0;
      end else if (m_pend) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %h expected %h", nm, edge_cnt, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (edge_cnt > 0) begin
      chk("rdy", {31'd0, data_resultRDY}, {31'd0, m_rdy});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("result", data_result, m_res);
      chk("exception", {31'd0, data_exception}, {31'd0, m_exc});
      if (lit_valid && data_resultRDY && edge_cnt == lit_edge + 33) begin
        chk("lit_result", data_result, lit_res);
        chk("lit_exception", {31'd0, data_exception}, {31'd0, lit_exc});
      end
      if (edge_cnt == lit_rst_edge) begin
        chk("rst_result", data_result, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
      end
    end
  end

  // Called at a negedge; drives a one-cycle start pulse, then scrambles the operands.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res,
                          input logic exc, input logic arm);
    #1;
    lit_edge      = edge_cnt + 1;
    lit_valid     = arm;
    lit_res       = res;
    lit_exc       = exc;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(negedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy();
    int k = 0;
    while (!data_resultRDY && k < 40) begin
      @(negedge clock);
      k++;
    end
  endtask

  typedef struct {
    logic        m;
    logic        d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        e;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'd5,          32'd0,         32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'd3,          32'd4,         32'd12,        1'b0};

    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);

    // back-to-back directed vectors: each start lands on the previous DONE edge
    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e, 1'b1);
      wait_rdy();
    end
    repeat (3) @(negedge clock);

    // restart: a divide issued at edge 10 of a multiply aborts it
    start_op(1'b1, 1'b0, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
    repeat (9) @(negedge clock);
    start_op(1'b0, 1'b1, 32'd9, 32'd3, 32'd3, 1'b0, 1'b1);
    wait_rdy();
    repeat (4) @(negedge clock);

    // reset at edge 15 of a multiply
    start_op(1'b1, 1'b0, 32'd7, 32'd9, 32'd0, 1'b0, 1'b0);
    repeat (14) @(negedge clock);
    #1;
    reset        = 1'b1;
    lit_rst_edge = edge_cnt + 1;
    @(negedge clock);
    #1;
    reset = 1'b0;
    repeat (40) @(negedge clock);

    start_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 1'b1);
    wait_rdy();
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
